// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: instruction layout, opcodes,
// ALU command and branch encodings, and default latencies.
package id_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned AW_DEF        = 5;
    localparam int unsigned CW_DEF        = 4;
    localparam int unsigned LAT_LOAD_DEF  = 1;
    localparam int unsigned LAT_NOFWD_DEF = 2;

    localparam int unsigned EXE_CMD_W = 4;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned SRC1_MSB = 25;
    localparam int unsigned SRC1_LSB = 21;
    localparam int unsigned SRC2_MSB = 20;
    localparam int unsigned SRC2_LSB = 16;
    localparam int unsigned RD_MSB   = 15;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_LSB  = 0;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd3,
        OP_AND  = 6'd5,
        OP_OR   = 6'd6,
        OP_NOR  = 6'd7,
        OP_XOR  = 6'd8,
        OP_SLA  = 6'd9,
        OP_SLL  = 6'd10,
        OP_SRA  = 6'd11,
        OP_SRL  = 6'd12,
        OP_ADDI = 6'd32,
        OP_SUBI = 6'd33,
        OP_LD   = 6'd36,
        OP_ST   = 6'd37,
        OP_BEZ  = 6'd40,
        OP_BNE  = 6'd41,
        OP_JMP  = 6'd42
    } opcode_e;

    typedef enum logic [EXE_CMD_W-1:0] {
        EXE_NONE = 4'd0,
        EXE_ADD  = 4'd1,
        EXE_SUB  = 4'd2,
        EXE_AND  = 4'd3,
        EXE_OR   = 4'd4,
        EXE_NOR  = 4'd5,
        EXE_XOR  = 4'd6,
        EXE_SHL  = 4'd7,
        EXE_SRA  = 4'd8,
        EXE_SRL  = 4'd9
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

endpackage

// File: rtl/Control_Unit.sv
// Opcode decoder: ALU command, memory/writeback enables, branch type and
// operand-shape flags for the decode stage.
module Control_Unit
    import id_pkg::*;
(
    input  logic [5:0]           opcode,
    output logic [EXE_CMD_W-1:0] exe_cmd,
    output logic [1:0]           br_type,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 wb_en,
    output logic                 is_immediate,
    output logic                 single_source,
    output logic                 branch_jump
);

    always_comb begin
        exe_cmd       = EXE_NONE;
        br_type       = BR_NONE;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        wb_en         = 1'b0;
        is_immediate  = 1'b0;
        single_source = 1'b0;
        branch_jump   = 1'b0;
        case (opcode)
            OP_ADD:  begin exe_cmd = EXE_ADD; wb_en = 1'b1; end
            OP_SUB:  begin exe_cmd = EXE_SUB; wb_en = 1'b1; end
            OP_AND:  begin exe_cmd = EXE_AND; wb_en = 1'b1; end
            OP_OR:   begin exe_cmd = EXE_OR;  wb_en = 1'b1; end
            OP_NOR:  begin exe_cmd = EXE_NOR; wb_en = 1'b1; end
            OP_XOR:  begin exe_cmd = EXE_XOR; wb_en = 1'b1; end
            OP_SLA,
            OP_SLL:  begin exe_cmd = EXE_SHL; wb_en = 1'b1; end
            OP_SRA:  begin exe_cmd = EXE_SRA; wb_en = 1'b1; end
            OP_SRL:  begin exe_cmd = EXE_SRL; wb_en = 1'b1; end
            OP_ADDI: begin
                exe_cmd = EXE_ADD; wb_en = 1'b1;
                is_immediate = 1'b1; single_source = 1'b1;
            end
            OP_SUBI: begin
                exe_cmd = EXE_SUB; wb_en = 1'b1;
                is_immediate = 1'b1; single_source = 1'b1;
            end
            OP_LD: begin
                exe_cmd = EXE_ADD; mem_read = 1'b1; wb_en = 1'b1;
                is_immediate = 1'b1; single_source = 1'b1;
            end
            OP_ST: begin
                exe_cmd = EXE_ADD; mem_write = 1'b1;
                is_immediate = 1'b1; single_source = 1'b1;
            end
            OP_BEZ: begin
                br_type = BR_BEZ; branch_jump = 1'b1;
                is_immediate = 1'b1; single_source = 1'b1;
            end
            OP_BNE: begin
                br_type = BR_BNE; branch_jump = 1'b1;
                is_immediate = 1'b1;
            end
            OP_JMP: begin
                br_type = BR_JMP; branch_jump = 1'b1;
                is_immediate = 1'b1; single_source = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/Sign_Extend.sv
// Sign-extends the 16-bit instruction immediate to the datapath width.
module Sign_Extend #(
    parameter int unsigned XLEN = 32
) (
    input  logic [15:0]     imm_in,
    output logic [XLEN-1:0] imm_out
);

    assign imm_out = {{(XLEN-16){imm_in[15]}}, imm_in};

endmodule

// File: rtl/id_scoreboard.sv
// Per-register busy countdown: a load port sets a counter on issue, every
// nonzero counter decrements each cycle, and two sources are queried.
module id_scoreboard
    import id_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_idx,
    input  logic [CW-1:0] ld_val,
    input  logic [AW-1:0] src1,
    input  logic [AW-1:0] src2,
    output logic          busy1,
    output logic          busy2
);

    localparam int unsigned NREG = 2**AW;

    logic [CW-1:0] cnt [NREG];

    // A load on the same index takes priority over that entry's decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (ld_en && (ld_idx == AW'(i)))
                    cnt[i] <= ld_val;
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    assign busy1 = (cnt[src1] != '0);
    assign busy2 = (cnt[src2] != '0);

endmodule

// File: rtl/id_scoreboard_stage.sv
// Decode stage: register file with write-through bypass, scoreboard-based
// hazard detection, and a registered ID/EX bundle with a valid bit.
module id_scoreboard_stage
    import id_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned CW        = CW_DEF,
    parameter bit          FWD_EN    = 1'b1,
    parameter int unsigned LAT_LOAD  = LAT_LOAD_DEF,
    parameter int unsigned LAT_NOFWD = LAT_NOFWD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [31:0]          if_instr,
    input  logic                 flush,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_dest,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 id_stall,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_val1,
    output logic [XLEN-1:0]      ex_val2,
    output logic [XLEN-1:0]      ex_reg2,
    output logic [AW-1:0]        ex_dest,
    output logic [AW-1:0]        ex_src1,
    output logic [AW-1:0]        ex_src2,
    output logic [EXE_CMD_W-1:0] ex_exe_cmd,
    output logic                 ex_mem_r_en,
    output logic                 ex_mem_w_en,
    output logic                 ex_wb_en,
    output logic [1:0]           ex_br_type,
    output logic [15:0]          stall_cnt
);

    localparam int unsigned NREG = 2**AW;

    logic [5:0]           opcode;
    logic [AW-1:0]        src1, src2, dest;
    logic [XLEN-1:0]      imm, rd1, rd2;
    logic [EXE_CMD_W-1:0] exe_cmd;
    logic [1:0]           br_type;
    logic                 mem_read, mem_write, wb_en;
    logic                 is_imm, single_source, branch_jump;
    logic                 src1_used, src2_used, busy1, busy2;
    logic                 hazard, issue, sb_load;
    logic [CW-1:0]        lat;
    logic [XLEN-1:0]      regs [NREG];

    assign opcode = if_instr[OPC_MSB:OPC_LSB];
    assign src1   = AW'(if_instr[SRC1_MSB:SRC1_LSB]);
    assign src2   = AW'(if_instr[SRC2_MSB:SRC2_LSB]);
    assign dest   = is_imm ? src2 : AW'(if_instr[RD_MSB:RD_LSB]);

    Control_Unit u_ctrl (
        .opcode        (opcode),
        .exe_cmd       (exe_cmd),
        .br_type       (br_type),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .wb_en         (wb_en),
        .is_immediate  (is_imm),
        .single_source (single_source),
        .branch_jump   (branch_jump)
    );

    Sign_Extend #(.XLEN(XLEN)) u_sext (
        .imm_in  (if_instr[IMM_MSB:IMM_LSB]),
        .imm_out (imm)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && (wb_dest != '0)) begin
            regs[wb_dest] <= wb_data;
        end
    end

    assign rd1 = (src1 == '0) ? '0 :
                 (wb_we && (wb_dest == src1)) ? wb_data : regs[src1];
    assign rd2 = (src2 == '0) ? '0 :
                 (wb_we && (wb_dest == src2)) ? wb_data : regs[src2];

    // Stores and branches read src2 even though they carry an immediate.
    assign src1_used = (opcode != OP_NOP);
    assign src2_used = !single_source || mem_write || branch_jump;

    assign hazard   = if_valid &&
                      ((src1_used && (src1 != '0) && busy1) ||
                       (src2_used && (src2 != '0) && busy2));
    assign id_stall = hazard && !flush;
    assign issue    = if_valid && !hazard && !flush;

    assign lat     = FWD_EN ? (mem_read ? CW'(LAT_LOAD) : '0) : CW'(LAT_NOFWD);
    assign sb_load = issue && wb_en && (dest != '0);

    id_scoreboard #(.AW(AW), .CW(CW)) u_sb (
        .clk    (clk),
        .rst    (rst),
        .ld_en  (sb_load),
        .ld_idx (dest),
        .ld_val (lat),
        .src1   (src1),
        .src2   (src2),
        .busy1  (busy1),
        .busy2  (busy2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_val1     <= '0;
            ex_val2     <= '0;
            ex_reg2     <= '0;
            ex_dest     <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_exe_cmd  <= '0;
            ex_mem_r_en <= 1'b0;
            ex_mem_w_en <= 1'b0;
            ex_wb_en    <= 1'b0;
            ex_br_type  <= '0;
        end else if (issue) begin
            ex_valid    <= 1'b1;
            ex_val1     <= rd1;
            ex_val2     <= is_imm ? imm : rd2;
            ex_reg2     <= rd2;
            ex_dest     <= dest;
            ex_src1     <= src1;
            ex_src2     <= src2;
            ex_exe_cmd  <= exe_cmd;
            ex_mem_r_en <= mem_read;
            ex_mem_w_en <= mem_write;
            ex_wb_en    <= wb_en;
            ex_br_type  <= br_type;
        end else begin
            ex_valid    <= 1'b0;
            ex_val1     <= '0;
            ex_val2     <= '0;
            ex_reg2     <= '0;
            ex_dest     <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_exe_cmd  <= '0;
            ex_mem_r_en <= 1'b0;
            ex_mem_w_en <= 1'b0;
            ex_wb_en    <= 1'b0;
            ex_br_type  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (id_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_id_scoreboard_stage.sv
// Directed bench: one instance with forwarding (load latency 1) and one
// without (latency 2), sharing stimulus; each section checks one instance.
module tb_id_scoreboard_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    logic        a_id_stall, a_ex_valid, a_ex_mem_r_en, a_ex_mem_w_en, a_ex_wb_en;
    logic [31:0] a_ex_val1, a_ex_val2, a_ex_reg2;
    logic [4:0]  a_ex_dest, a_ex_src1, a_ex_src2;
    logic [3:0]  a_ex_exe_cmd;
    logic [1:0]  a_ex_br_type;
    logic [15:0] a_stall_cnt;

    logic        b_id_stall, b_ex_valid, b_ex_mem_r_en, b_ex_mem_w_en, b_ex_wb_en;
    logic [31:0] b_ex_val1, b_ex_val2, b_ex_reg2;
    logic [4:0]  b_ex_dest, b_ex_src1, b_ex_src2;
    logic [3:0]  b_ex_exe_cmd;
    logic [1:0]  b_ex_br_type;
    logic [15:0] b_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_scoreboard_stage #(.FWD_EN(1'b1), .LAT_LOAD(1)) dut_a (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .flush(flush), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
        .id_stall(a_id_stall), .ex_valid(a_ex_valid),
        .ex_val1(a_ex_val1), .ex_val2(a_ex_val2), .ex_reg2(a_ex_reg2),
        .ex_dest(a_ex_dest), .ex_src1(a_ex_src1), .ex_src2(a_ex_src2),
        .ex_exe_cmd(a_ex_exe_cmd), .ex_mem_r_en(a_ex_mem_r_en),
        .ex_mem_w_en(a_ex_mem_w_en), .ex_wb_en(a_ex_wb_en),
        .ex_br_type(a_ex_br_type), .stall_cnt(a_stall_cnt)
    );

    id_scoreboard_stage #(.FWD_EN(1'b0), .LAT_NOFWD(2)) dut_b (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .flush(flush), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
        .id_stall(b_id_stall), .ex_valid(b_ex_valid),
        .ex_val1(b_ex_val1), .ex_val2(b_ex_val2), .ex_reg2(b_ex_reg2),
        .ex_dest(b_ex_dest), .ex_src1(b_ex_src1), .ex_src2(b_ex_src2),
        .ex_exe_cmd(b_ex_exe_cmd), .ex_mem_r_en(b_ex_mem_r_en),
        .ex_mem_w_en(b_ex_mem_w_en), .ex_wb_en(b_ex_wb_en),
        .ex_br_type(b_ex_br_type), .stall_cnt(b_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rs1, rs2, rd, 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rs1, rt, imm};
    endfunction

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_instr = '0; flush = 1'b0;
        wb_we = 1'b0; wb_dest = '0; wb_data = '0;

        // Reset state
        #12;
        check("rst_a_valid", {31'd0, a_ex_valid}, 32'd0);
        check("rst_a_stallcnt", {16'd0, a_stall_cnt}, 32'd0);
        check("rst_a_val1", a_ex_val1, 32'd0);
        check("rst_b_valid", {31'd0, b_ex_valid}, 32'd0);
        check("rst_a_stall", {31'd0, a_id_stall}, 32'd0);
        rst = 1'b1;
        tick();

        // r1=5, r2=7 then ADD r3,r1,r2
        wb_we = 1'b1; wb_dest = 5'd1; wb_data = 32'd5; tick();
        wb_dest = 5'd2; wb_data = 32'd7; tick();
        wb_we = 1'b0;
        if_valid = 1'b1; if_instr = r_ins(6'd1, 5'd3, 5'd1, 5'd2);
        #1 check("add_stall", {31'd0, a_id_stall}, 32'd0);
        tick();
        check("add_valid", {31'd0, a_ex_valid}, 32'd1);
        check("add_val1", a_ex_val1, 32'd5);
        check("add_val2", a_ex_val2, 32'd7);
        check("add_reg2", a_ex_reg2, 32'd7);
        check("add_dest", {27'd0, a_ex_dest}, 32'd3);
        check("add_cmd", {28'd0, a_ex_exe_cmd}, 32'd1);
        check("add_wb", {31'd0, a_ex_wb_en}, 32'd1);
        check("add_stallcnt", {16'd0, a_stall_cnt}, 32'd0);

        // FWD_EN=1: LD r4,8(r1) then ADD r5,r4,r1 -> one stall
        if_instr = i_ins(6'd36, 5'd4, 5'd1, 16'd8);
        tick();
        check("ld_mem_r", {31'd0, a_ex_mem_r_en}, 32'd1);
        check("ld_dest", {27'd0, a_ex_dest}, 32'd4);
        check("ld_val1", a_ex_val1, 32'd5);
        check("ld_val2", a_ex_val2, 32'd8);
        if_instr = r_ins(6'd1, 5'd5, 5'd4, 5'd1);
        #1 check("lduse_stall", {31'd0, a_id_stall}, 32'd1);
        tick();
        check("lduse_bubble", {31'd0, a_ex_valid}, 32'd0);
        check("lduse_bubble_wb", {31'd0, a_ex_wb_en}, 32'd0);
        check("lduse_unstall", {31'd0, a_id_stall}, 32'd0);
        tick();
        check("lduse_issue", {31'd0, a_ex_valid}, 32'd1);
        check("lduse_dest", {27'd0, a_ex_dest}, 32'd5);
        check("lduse_src1", {27'd0, a_ex_src1}, 32'd4);
        check("lduse_stallcnt", {16'd0, a_stall_cnt}, 32'd1);
        if_valid = 1'b0;

        // FWD_EN=0: ADDI r6,r0,9 then SUB r7,r6,r6 -> two stalls
        do_reset();
        if_valid = 1'b1; if_instr = i_ins(6'd32, 5'd6, 5'd0, 16'd9);
        #1 check("addi_stall", {31'd0, b_id_stall}, 32'd0);
        tick();
        check("addi_valid", {31'd0, b_ex_valid}, 32'd1);
        check("addi_val1", b_ex_val1, 32'd0);
        check("addi_val2", b_ex_val2, 32'd9);
        check("addi_dest", {27'd0, b_ex_dest}, 32'd6);
        if_instr = r_ins(6'd3, 5'd7, 5'd6, 5'd6);
        #1 check("sub_stall0", {31'd0, b_id_stall}, 32'd1);
        tick();
        check("sub_bubble1", {31'd0, b_ex_valid}, 32'd0);
        check("sub_bubble1_wb", {31'd0, b_ex_wb_en}, 32'd0);
        check("sub_stall1", {31'd0, b_id_stall}, 32'd1);
        tick();
        check("sub_bubble2", {31'd0, b_ex_valid}, 32'd0);
        check("sub_stall2", {31'd0, b_id_stall}, 32'd0);
        tick();
        check("sub_issue", {31'd0, b_ex_valid}, 32'd1);
        check("sub_dest", {27'd0, b_ex_dest}, 32'd7);
        check("sub_cmd", {28'd0, b_ex_exe_cmd}, 32'd2);
        check("sub_stallcnt", {16'd0, b_stall_cnt}, 32'd2);

        // Same-cycle writeback bypass, r0 protection, sign extension, store
        if_instr = r_ins(6'd1, 5'd9, 5'd8, 5'd0);
        wb_we = 1'b1; wb_dest = 5'd8; wb_data = 32'h0000_DEAD;
        tick();
        check("byp_val1", a_ex_val1, 32'h0000_DEAD);
        check("byp_val2_r0", a_ex_val2, 32'd0);
        wb_dest = 5'd0; wb_data = 32'h0000_1234;
        if_instr = r_ins(6'd1, 5'd10, 5'd0, 5'd8);
        tick();
        check("wb_r0_val1", a_ex_val1, 32'd0);
        check("r8_stored", a_ex_val2, 32'h0000_DEAD);
        wb_we = 1'b0;
        if_instr = i_ins(6'd36, 5'd0, 5'd8, 16'd4);
        tick();
        check("ld_r0_dest", {27'd0, a_ex_dest}, 32'd0);
        if_instr = r_ins(6'd1, 5'd11, 5'd0, 5'd0);
        #1 check("r0_never_busy", {31'd0, a_id_stall}, 32'd0);
        if_instr = i_ins(6'd33, 5'd14, 5'd8, 16'hFFF0);
        tick();
        check("sext_val2", a_ex_val2, 32'hFFFF_FFF0);
        check("sext_val1", a_ex_val1, 32'h0000_DEAD);
        check("subi_cmd", {28'd0, a_ex_exe_cmd}, 32'd2);
        if_instr = i_ins(6'd37, 5'd8, 5'd9, 16'd4);
        tick();
        check("st_mem_w", {31'd0, a_ex_mem_w_en}, 32'd1);
        check("st_wb", {31'd0, a_ex_wb_en}, 32'd0);
        check("st_reg2", a_ex_reg2, 32'h0000_DEAD);
        if_valid = 1'b0;
        tick();
        check("idle_valid", {31'd0, a_ex_valid}, 32'd0);
        check("idle_mem_w", {31'd0, a_ex_mem_w_en}, 32'd0);

        // Flush during a hazard (FWD_EN=0, latency 2)
        do_reset();
        if_valid = 1'b1; if_instr = i_ins(6'd36, 5'd12, 5'd1, 16'd0);
        tick();
        if_instr = r_ins(6'd1, 5'd13, 5'd12, 5'd1);
        flush = 1'b1;
        #1 check("flush_stall", {31'd0, b_id_stall}, 32'd0);
        tick();
        check("flush_bubble", {31'd0, b_ex_valid}, 32'd0);
        flush = 1'b0;
        #1 check("post_flush_stall", {31'd0, b_id_stall}, 32'd1);
        tick();
        check("post_flush_bubble", {31'd0, b_ex_valid}, 32'd0);
        check("post_flush_unstall", {31'd0, b_id_stall}, 32'd0);
        tick();
        check("post_flush_issue", {31'd0, b_ex_valid}, 32'd1);
        check("post_flush_dest", {27'd0, b_ex_dest}, 32'd13);
        check("flush_stallcnt", {16'd0, b_stall_cnt}, 32'd1);

        // Reset asserted mid-stall with busy[4]=1
        do_reset();
        if_instr = i_ins(6'd36, 5'd4, 5'd1, 16'd0);
        tick();
        if_instr = r_ins(6'd1, 5'd5, 5'd4, 5'd4);
        #1 check("mid_stall0", {31'd0, b_id_stall}, 32'd1);
        tick();
        check("mid_stall1", {31'd0, b_id_stall}, 32'd1);
        check("mid_stallcnt", {16'd0, b_stall_cnt}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_stallcnt", {16'd0, b_stall_cnt}, 32'd0);
        check("rst_mid_valid", {31'd0, b_ex_valid}, 32'd0);
        check("rst_mid_dest", {27'd0, b_ex_dest}, 32'd0);
        check("rst_mid_stall", {31'd0, b_id_stall}, 32'd0);
        rst = 1'b1;
        #1 check("rel_stall", {31'd0, b_id_stall}, 32'd0);
        tick();
        check("rel_issue", {31'd0, b_ex_valid}, 32'd1);
        check("rel_dest", {27'd0, b_ex_dest}, 32'd5);
        check("rel_stallcnt", {16'd0, b_stall_cnt}, 32'd0);
        if_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
